vt52_stream_arbiter: RTL and testbench
======================================

VT52_STREAM_ARBITER -- requirements
Module: vt52_stream_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, stall limit in clk cycles for a locked escape sequence; legal range 1..65535; 16-bit counter.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high.
REQ-004 Port: a_data, input, 8, source A byte (UART receive FIFO).
REQ-005 Port: a_valid, input, 1, source A byte available.
REQ-006 Port: a_ready, output, 1, source A byte accepted this cycle when high together with a_valid.
REQ-007 Port: b_data, input, 8, source B byte (local status/message generator).
REQ-008 Port: b_valid, input, 1, source B byte available.
REQ-009 Port: b_ready, output, 1, source B byte accepted this cycle when high together with b_valid.
REQ-010 Port: out_data, output, 8, byte to command handler.
REQ-011 Port: out_valid, output, 1, out_data valid.
REQ-012 Port: out_ready, input, 1, command handler accepts byte.
REQ-013 Port: owner, output, 1, currently selected source; 0 = A, 1 = B.
REQ-014 Port: busy, output, 1, high while an escape sequence holds the lock.
REQ-015 Port: seq_abort, output, 1, one-cycle pulse when the timeout breaks a lock.

Function
REQ-016 Datapath SHALL be combinational pass-through, zero latency: out_valid = selected valid, out_data = selected data, selected ready = out_ready, unselected ready = 0.
REQ-017 out_data SHALL be 8'h00 whenever out_valid is low.
REQ-018 Transfer SHALL be defined as out_valid && out_ready; only transfers advance state.
REQ-019 States: IDLE, ESC1, ARG2, ARG1; busy = (state != IDLE).
REQ-020 IDLE selection: only one valid -> that source; both valid -> source not equal to last (round robin); none valid -> owner = !last, out_valid = 0.
REQ-021 IDLE transfer: last <= owner; byte 8'h1B -> ESC1 with owner locked; any other byte -> stay IDLE.
REQ-022 In ESC1, ARG2 and ARG1, owner SHALL stay locked; the other source's ready SHALL be 0 even if out_ready is high.
REQ-023 ESC1 transfer: byte 8'h59 ('Y') -> ARG2; any other byte -> IDLE.
REQ-024 ARG2 transfer -> ARG1; ARG1 transfer -> IDLE. Bytes in ARG2/ARG1 are not decoded, including 8'h1B.
REQ-025 While out_ready is low, the owner's valid is held, or no transfer occurs, state and owner SHALL not change.

Reset
REQ-026 On reset: state = IDLE, last = 1 (A wins the first tie), timeout counter = 0, seq_abort = 0.
REQ-027 Reset during ESC1/ARG2/ARG1 SHALL drop the lock on the next edge; no partial-sequence bookkeeping is retained.
REQ-028 Outputs during reset follow REQ-016/REQ-020 combinationally from the reset state.

Configuration
REQ-029 Macro STREAM_ARB_TIMEOUT_EN, when defined, SHALL compile in the stall watchdog described in REQ-030 to REQ-032.
REQ-030 With the macro: in non-IDLE states the counter increments each cycle without a transfer and clears on a transfer or in IDLE.
REQ-031 With the macro: when the counter reaches TIMEOUT_CYCLES, state -> IDLE, counter -> 0, seq_abort pulses high for exactly 1 cycle, last <= owner.
REQ-032 With the macro: a transfer in the same cycle the limit is reached SHALL take precedence; the sequence advances and there is no abort.
REQ-033 Without the macro: no counter is present, seq_abort is tied 0, and the lock is held indefinitely.

Verification
REQ-034 Both valid after reset, out_ready=1, A sends 'H', B sends 'i' -> out sequence 'H','i','H','i' alternating; owner toggles 0,1,0,1.
REQ-035 A sends 1B 59 25 30 while B valid continuously -> all four A bytes are contiguous, b_ready=0 throughout, busy=1 for 3 cycles; then B is granted.
REQ-036 B sends 1B 48 ('ESC H'), A valid -> two B bytes are contiguous, then IDLE, then A is granted.
REQ-037 out_ready=0 for 5 cycles in ARG2 -> state, owner and out_data stable; resumes to ARG1 on release.
REQ-038 With STREAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, A sends 1B then a_valid=0 -> seq_abort pulses exactly 8 cycles after the ESC transfer; pending B is granted the next cycle.
REQ-039 reset asserted in ARG1 -> next cycle busy=0, seq_abort=0, A wins a tie.

Source files
------------

// File: rtl/vt52_stream_arbiter.sv
// ---------------------------------------------------------------------------
// vt52_stream_arbiter
//
// Purpose:
//   Merges two byte streams (A: UART receive FIFO, B: local status/message
//   generator) into a single command-handler stream. Sources are normally
//   round-robin arbitrated, but a VT52 escape sequence (ESC, or ESC 'Y' row col)
//   locks the arbiter to the source that started it until the sequence ends,
//   so sequence bytes from one source are never interleaved with the other.
//
// Datapath is a zero-latency combinational pass-through; only the arbitration
// state is registered.
//
// Ports:
//   clk        - single clock, all state updates on rising edge
//   reset      - synchronous, active-high
//   a_data/a_valid/a_ready - source A byte stream
//   b_data/b_valid/b_ready - source B byte stream
//   out_data/out_valid/out_ready - merged stream to the command handler
//   owner      - selected source (0 = A, 1 = B)
//   busy       - high while an escape sequence holds the lock
//   seq_abort  - one-cycle pulse when the stall watchdog breaks a lock
//
// Configuration:
//   STREAM_ARB_TIMEOUT_EN - when defined, compiles in a stall watchdog that
//   breaks a lock after TIMEOUT_CYCLES cycles without a transfer. When not
//   defined, no counter exists, seq_abort is tied low and a lock is held
//   indefinitely.
// ---------------------------------------------------------------------------
module vt52_stream_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       owner,
  output logic       busy,
  output logic       seq_abort
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ESC1 = 2'd1;
  localparam logic [1:0] ST_ARG2 = 2'd2;
  localparam logic [1:0] ST_ARG1 = 2'd3;

  localparam logic [7:0] ESC_BYTE = 8'h1B;
  localparam logic [7:0] Y_BYTE   = 8'h59;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  // last_r doubles as the locked owner: entering a sequence records the owner.
  logic       last_r;
  logic       last_nxt_s;
  logic       owner_s;
  logic       sel_valid_s;
  logic [7:0] sel_data_s;
  logic       xfer_s;
  logic       timeout_s;

  // Source selection: locked owner outside IDLE, otherwise round robin.
  always_comb begin
    owner_s = ~last_r;
    if (state_r != ST_IDLE) begin
      owner_s = last_r;
    end else if (a_valid && !b_valid) begin
      owner_s = 1'b0;
    end else if (b_valid && !a_valid) begin
      owner_s = 1'b1;
    end else begin
      owner_s = ~last_r;
    end
  end

  // Pass-through datapath; data forced to zero when nothing is presented.
  always_comb begin
    sel_valid_s = owner_s ? b_valid : a_valid;
    if (sel_valid_s) begin
      sel_data_s = owner_s ? b_data : a_data;
    end else begin
      sel_data_s = 8'h00;
    end
  end

  assign xfer_s    = sel_valid_s && out_ready;
  assign out_valid = sel_valid_s;
  assign out_data  = sel_data_s;
  assign a_ready   = ~owner_s & out_ready;
  assign b_ready   = owner_s & out_ready;
  assign owner     = owner_s;
  assign busy      = (state_r != ST_IDLE);

  // Escape-sequence decoder; only transfers advance it.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          last_nxt_s = owner_s;
          if (sel_data_s == ESC_BYTE) begin
            state_nxt_s = ST_ESC1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ESC1: begin
        if (xfer_s) begin
          state_nxt_s = (sel_data_s == Y_BYTE) ? ST_ARG2 : ST_IDLE;
        end else begin
          state_nxt_s = ST_ESC1;
        end
      end
      ST_ARG2: begin
        if (xfer_s) begin
          state_nxt_s = ST_ARG1;
        end else begin
          state_nxt_s = ST_ARG2;
        end
      end
      ST_ARG1: begin
        if (xfer_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARG1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_cnt_r;
  logic [15:0] stall_cnt_nxt_s;
  logic        seq_abort_r;

  // Stall watchdog: the limit fires on the edge that would bring the count
  // to TIMEOUT_CYCLES; a transfer in that cycle clears it instead.
  always_comb begin
    stall_cnt_nxt_s = 16'd0;
    timeout_s       = 1'b0;
    if ((state_r != ST_IDLE) && !xfer_s) begin
      if ((stall_cnt_r + 16'd1) == TIMEOUT_L) begin
        timeout_s       = 1'b1;
        stall_cnt_nxt_s = 16'd0;
      end else begin
        stall_cnt_nxt_s = stall_cnt_r + 16'd1;
      end
    end else begin
      stall_cnt_nxt_s = 16'd0;
    end
  end

  // Watchdog counter and registered abort pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
      seq_abort_r <= 1'b0;
    end else begin
      stall_cnt_r <= stall_cnt_nxt_s;
      seq_abort_r <= timeout_s;
    end
  end

  assign seq_abort = seq_abort_r;
`else
  assign timeout_s = 1'b0;
  assign seq_abort = 1'b0;
`endif

  // Arbitration state; an abort returns to IDLE with last keeping the owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
    end else if (timeout_s) begin
      state_r <= ST_IDLE;
      last_r  <= last_r;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

endmodule

// File: tb/tb_vt52_stream_arbiter.sv
module tb_vt52_stream_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_data, b_data, out_data;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic       out_valid, out_ready, owner, busy, seq_abort;

  vt52_stream_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .owner(owner), .busy(busy), .seq_abort(seq_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       own;
    logic       vld;
    logic [7:0] data;
    logic       ar;
    logic       br;
    logic       bsy;
    logic       abrt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the bytes of the escape sequence in progress are kept
  // in a list; an empty list means the arbiter is free.
  logic       m_last  = 1'b1;
  logic [7:0] m_seq[$];
  int         m_stall = 0;
  logic       m_abort = 1'b0;

  task automatic step(input logic av, input logic [7:0] ad, input logic bv,
                      input logic [7:0] bd, input logic rdy, input logic rst);
    exp_t e;
    logic own, vld, xfer;
    logic [7:0] d;
    logic abort_next;
    @(negedge clk);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    out_ready = rdy; reset = rst;
    if (m_seq.size() != 0) own = m_last;
    else if (av && !bv)    own = 1'b0;
    else if (bv && !av)    own = 1'b1;
    else                   own = ~m_last;
    vld  = own ? bv : av;
    d    = vld ? (own ? bd : ad) : 8'h00;
    xfer = vld && rdy;
    e.own = own; e.vld = vld; e.data = d;
    e.ar = !own && rdy; e.br = own && rdy;
    e.bsy = (m_seq.size() != 0); e.abrt = m_abort;
    exp_q.push_back(e);
    abort_next = 1'b0;
    if (rst) begin
      m_seq.delete(); m_last = 1'b1; m_stall = 0;
    end else if (m_seq.size() == 0) begin
      m_stall = 0;
      if (xfer) begin
        m_last = own;
        if (d == 8'h1B) m_seq.push_back(d);
      end
    end else if (xfer) begin
      m_stall = 0;
      m_seq.push_back(d);
      if ((m_seq.size() == 2 && m_seq[1] != 8'h59) || m_seq.size() == 4)
        m_seq.delete();
    end else begin
      m_stall++;
`ifdef STREAM_ARB_TIMEOUT_EN
      if (m_stall == TO) begin
        m_seq.delete(); m_stall = 0; abort_next = 1'b1;
      end
`endif
    end
    m_abort = abort_next;
  endtask

  // Monitor: compares each presented output cycle against the queued expectation.
  initial begin
    exp_t e, g;
    int cyc = 0;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.own = owner; g.vld = out_valid; g.data = out_data;
        g.ar = a_ready; g.br = b_ready; g.bsy = busy; g.abrt = seq_abort;
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle%0d got own=%b vld=%b data=%h ar=%b br=%b busy=%b abort=%b want own=%b vld=%b data=%h ar=%b br=%b busy=%b abort=%b",
                   cyc, g.own, g.vld, g.data, g.ar, g.br, g.bsy, g.abrt,
                   e.own, e.vld, e.data, e.ar, e.br, e.bsy, e.abrt);
        end
        cyc++;
      end
    end
  end

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0)      return 8'h1B;
    else if (r == 1) return 8'h59;
    else             return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int wait_cyc;
    logic [7:0] seq35[4];
    seq35[0] = 8'h1B; seq35[1] = 8'h59; seq35[2] = 8'h25; seq35[3] = 8'h30;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00; out_ready = 1'b0;
    @(posedge clk);
    // Reset state, outputs during reset.
    step(1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    // Alternating H / i with both sources valid.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h48, 1'b1, 8'h69, 1'b1, 1'b0);
    // A sends ESC Y row col while B waits; then B gets its turn.
    for (int i = 0; i < 4; i++) step(1'b1, seq35[i], 1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b1, 8'h41, 1'b1, 8'h5A, 1'b1, 1'b0);
    // B sends ESC H; A waiting, then A granted.
    step(1'b0, 8'h00, 1'b1, 8'h1B, 1'b1, 1'b0);
    step(1'b1, 8'h41, 1'b1, 8'h48, 1'b1, 1'b0);
    step(1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0);
    // Back-pressure in ARG2.
    step(1'b1, 8'h1B, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h59, 1'b1, 8'h42, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h20, 1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h21, 1'b1, 8'h42, 1'b1, 1'b0);
    // Stalled lock: A sends ESC then goes idle with B pending.
    step(1'b1, 8'h1B, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < TO + 4; i++) step(1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    // Reset in ARG1 drops the lock; A wins the next tie.
    step(1'b1, 8'h1B, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h59, 1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h21, 1'b1, 8'h42, 1'b1, 1'b1);
    step(1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_byte(),
           $urandom_range(0, 3) != 0, rand_byte(),
           $urandom_range(0, 4) != 0, $urandom_range(0, 199) == 0);
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
